xilinx_dram_fifo: RTL and testbench



---
 rtl/xilinx_dram_fifo_pkg.sv | 17 +
 rtl/xilinx_dram_fifo_array.sv | 29 ++
 rtl/xilinx_dram_fifo.sv | 92 +++++++++
 tb/tb_xilinx_dram_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/xilinx_dram_fifo_pkg.sv
// Shared constants and elaboration helpers for the LUTRAM-backed FWFT FIFO.
package xilinx_dram_fifo_pkg;

   // Only the 32/64/128-deep dual-port LUTRAM primitives are supported.
   function automatic bit abits_legal(input int abits);
      return (abits >= 32'sd5) && (abits <= 32'sd7);
   endfunction

   function automatic int depth_of(input int abits);
      return 32'sd1 << abits;
   endfunction

   function automatic int ptrw_of(input int abits);
      return abits + 32'sd1;
   endfunction

endpackage

// File: rtl/xilinx_dram_fifo_array.sv
// WIDTH x 2^ABITS dual-port LUTRAM: synchronous write port B1, asynchronous read port A1.
module xilinx_dram_fifo_array
   import xilinx_dram_fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ABITS = 6
) (
   input  logic             CLK1,
   input  logic [ABITS-1:0] A1ADDR,
   output logic [WIDTH-1:0] A1DATA,
   input  logic [ABITS-1:0] B1ADDR,
   input  logic [WIDTH-1:0] B1DATA,
   input  logic             B1EN
);

   localparam int DEPTH = depth_of(ABITS);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Write port; storage is deliberately unreset so it maps onto LUTRAM.
   always_ff @(posedge CLK1) begin
      if (B1EN) begin
         mem_r[B1ADDR] <= B1DATA;
      end
   end

   assign A1DATA = mem_r[A1ADDR];

endmodule

// File: rtl/xilinx_dram_fifo.sv
// First-word-fall-through FIFO: LUTRAM storage plus one registered output stage.
module xilinx_dram_fifo
   import xilinx_dram_fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ABITS = 6
) (
   input  logic             CLK1,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] WR_DATA,
   input  logic             WR_VALID,
   output logic             WR_READY,
   output logic [WIDTH-1:0] RD_DATA,
   output logic             RD_VALID,
   input  logic             RD_READY,
   output logic [ABITS:0]   LEVEL
);

   localparam int PTRW = ptrw_of(ABITS);

   if (!abits_legal(ABITS)) begin : g_abits_illegal
      $error("xilinx_dram_fifo: ABITS must be 5, 6 or 7");
   end

   logic [PTRW-1:0]  wr_ptr_r;
   logic [PTRW-1:0]  rd_ptr_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] out_data_r;
   logic [WIDTH-1:0] ram_rd_data_s;
   logic             ram_empty_s;
   logic             ram_full_s;
   logic             wr_fire_s;
   logic             load_s;
   logic             ram_we_s;

   // Occupancy flags and handshakes, all derived from registered state.
   always_comb begin
      ram_empty_s = 1'b0;
      ram_full_s  = 1'b0;
      if (wr_ptr_r == rd_ptr_r) begin
         ram_empty_s = 1'b1;
      end else if ((wr_ptr_r[PTRW-1] != rd_ptr_r[PTRW-1]) &&
                   (wr_ptr_r[PTRW-2:0] == rd_ptr_r[PTRW-2:0])) begin
         ram_full_s = 1'b1;
      end else begin
         ram_full_s = 1'b0;
      end
      wr_fire_s = WR_VALID & ~ram_full_s;
      load_s    = ~ram_empty_s & (~out_valid_r | RD_READY);
      // Gating with RST_N keeps the RAM untouched while reset is held.
      ram_we_s  = wr_fire_s & RST_N;
   end

   xilinx_dram_fifo_array #(
      .WIDTH (WIDTH),
      .ABITS (ABITS)
   ) u_array (
      .CLK1   (CLK1),
      .A1ADDR (rd_ptr_r[PTRW-2:0]),
      .A1DATA (ram_rd_data_s),
      .B1ADDR (wr_ptr_r[PTRW-2:0]),
      .B1DATA (WR_DATA),
      .B1EN   (ram_we_s)
   );

   // Pointers and the output stage that turns the async read into a stream.
   always_ff @(posedge CLK1 or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_r    <= {PTRW{1'b0}};
         rd_ptr_r    <= {PTRW{1'b0}};
         out_valid_r <= 1'b0;
         out_data_r  <= {WIDTH{1'b0}};
      end else begin
         if (wr_fire_s) begin
            wr_ptr_r <= wr_ptr_r + {{(PTRW-1){1'b0}}, 1'b1};
         end
         if (load_s) begin
            out_data_r  <= ram_rd_data_s;
            rd_ptr_r    <= rd_ptr_r + {{(PTRW-1){1'b0}}, 1'b1};
            out_valid_r <= 1'b1;
         end else if (out_valid_r && RD_READY) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign WR_READY = ~ram_full_s;
   assign RD_VALID = out_valid_r;
   assign RD_DATA  = out_data_r;
   assign LEVEL    = (wr_ptr_r - rd_ptr_r) + {{(PTRW-1){1'b0}}, out_valid_r};

endmodule

// File: tb/tb_xilinx_dram_fifo.sv
// Randomised and directed checks of xilinx_dram_fifo for ABITS = 5, 6 and 7 against a queue model.
module tb_xilinx_dram_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       rd_ready;
   logic       wr_ready [3];
   logic       rd_valid [3];
   logic [7:0] rd_data  [3];
   logic [7:0] level    [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s inst%0d got=%0h exp=%0h at %0t", name, inst, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int A   = 5 + g;
      localparam int CAP = 1 << A;

      logic [A:0] lv;
      logic [7:0] q [$];
      bit         mv;
      logic [7:0] md;
      bit         fire;
      bit         ld;

      xilinx_dram_fifo #(.WIDTH(8), .ABITS(A)) u_dut (
         .CLK1     (clk),
         .RST_N    (rst_n),
         .WR_DATA  (wr_data),
         .WR_VALID (wr_valid),
         .WR_READY (wr_ready[g]),
         .RD_DATA  (rd_data[g]),
         .RD_VALID (rd_valid[g]),
         .RD_READY (rd_ready),
         .LEVEL    (lv)
      );
      assign level[g] = 8'(lv);

      // Reference: a queue for the RAM plus one output slot.
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q.delete();
            mv = 1'b0;
            md = 8'h00;
         end else begin
            fire = wr_valid && (q.size() < CAP);
            ld   = (q.size() > 0) && (!mv || rd_ready);
            if (ld) begin
               md = q.pop_front();
               mv = 1'b1;
            end else if (mv && rd_ready) begin
               mv = 1'b0;
            end
            if (fire) q.push_back(wr_data);
         end
      end

      // Compare every cycle away from the active edge.
      always @(negedge clk) begin
         chk("level",    g, 32'(level[g]), 32'(q.size()) + 32'(mv));
         chk("wr_ready", g, 32'(wr_ready[g]), 32'(q.size() < CAP));
         chk("rd_valid", g, 32'(rd_valid[g]), 32'(mv));
         chk("rd_data",  g, 32'(rd_data[g]), 32'(md));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   int cnt;
   int exp_seq;
   bit f;
   int wp;
   int rp;

   initial begin
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      wr_data  = 8'h00;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Reset state.
      @(negedge clk);
      chk("rst_level", 1, 32'(level[1]), 32'd0);
      chk("rst_valid", 1, 32'(rd_valid[1]), 32'd0);
      chk("rst_data",  1, 32'(rd_data[1]), 32'd0);
      chk("rst_wrrdy", 1, 32'(wr_ready[1]), 32'd1);

      // Single write: level first, data one edge later.
      tick();
      wr_valid = 1'b1;
      wr_data  = 8'h11;
      tick();
      wr_valid = 1'b0;
      @(negedge clk);
      chk("lat_valid0", 1, 32'(rd_valid[1]), 32'd0);
      chk("lat_level0", 1, 32'(level[1]), 32'd1);
      @(negedge clk);
      chk("lat_valid1", 1, 32'(rd_valid[1]), 32'd1);
      chk("lat_data1",  1, 32'(rd_data[1]), 32'h11);
      chk("lat_level1", 1, 32'(level[1]), 32'd1);

      // Fill to 65 words, then prove further writes are ignored.
      do_reset();
      for (int i = 0; i < 65; i++) begin
         wr_data  = 8'(i);
         wr_valid = 1'b1;
         @(negedge clk);
         chk("fill_wrrdy", 1, 32'(wr_ready[1]), 32'd1);
         tick();
      end
      wr_data = 8'hAA;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("full_level", 1, 32'(level[1]), 32'd65);
         chk("full_wrrdy", 1, 32'(wr_ready[1]), 32'd0);
         chk("full_head",  1, 32'(rd_data[1]), 32'h00);
         tick();
      end

      // Streaming from full across pointer wrap: output must be strictly sequential.
      cnt      = 65;
      exp_seq  = 0;
      rd_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         wr_data  = 8'(cnt);
         wr_valid = 1'b1;
         @(negedge clk);
         f = wr_ready[1];
         if (rd_valid[1]) begin
            chk("stream_seq", 1, 32'(rd_data[1]), 32'(exp_seq[7:0]));
            exp_seq++;
         end
         tick();
         if (f) cnt++;
      end
      chk("stream_count", 1, 32'(exp_seq), 32'd200);

      // Concurrent write and read from a near-empty FIFO.
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      do_reset();
      wr_valid = 1'b1;
      wr_data  = 8'h5A;
      tick();
      rd_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         wr_data = 8'($urandom);
         tick();
      end

      // Asynchronous reset in the middle of a burst.
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'(8'hC0 + i);
         tick();
      end
      wr_valid = 1'b1;
      @(negedge clk);
      chk("mid_level", 1, 32'(level[1]), 32'd30);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", 1, 32'(rd_valid[1]), 32'd0);
      chk("arst_data",  1, 32'(rd_data[1]), 32'd0);
      chk("arst_level", 1, 32'(level[1]), 32'd0);
      chk("arst_wrrdy", 1, 32'(wr_ready[1]), 32'd1);
      wr_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      rd_ready = 1'b1;
      repeat (3) tick();

      // Random traffic under several fill/drain biases.
      for (int r = 0; r < 6; r++) begin
         wp = $urandom_range(10, 95);
         rp = $urandom_range(10, 95);
         for (int i = 0; i < 500; i++) begin
            wr_valid = ($urandom_range(0, 99) < wp);
            rd_ready = ($urandom_range(0, 99) < rp);
            wr_data  = 8'($urandom);
            tick();
         end
      end

      wr_valid = 1'b0;
      rd_ready = 1'b0;
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
